fetch_byte_queue: RTL and testbench



---
 rtl/fetch_byte_queue_pkg.sv | 28 ++
 rtl/fetch_byte_queue_if.sv | 31 +++
 rtl/fetch_byte_queue_predecode.sv | 20 ++
 rtl/fetch_byte_queue.sv | 119 +++++++++++
 tb/tb_fetch_byte_queue.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_byte_queue_pkg.sv
// fetch_pkg: icode constants, default queue depth and pre-decode helpers for fetch_byte_queue.
package fetch_pkg;
    localparam int QDEPTH_DEF = 16;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    function automatic logic f_need_regids(input logic [3:0] icode);
        return icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
    endfunction

    function automatic logic f_need_valc(input logic [3:0] icode);
        return icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
    endfunction

    function automatic logic [3:0] f_instr_len(input logic need_regids, input logic need_valc);
        return 4'd1 + {3'd0, need_regids} + (need_valc ? 4'd8 : 4'd0);
    endfunction
endpackage

// File: rtl/fetch_byte_queue_if.sv
// fetch_byte_queue_if: instruction-memory read port, redirect and instruction-window handshake.
interface fetch_byte_queue_if #(parameter int ADDR_W = 64);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [63:0]       imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [79:0]       win_bytes;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic              need_regids;
    logic              need_valC;
    logic [3:0]        instr_len;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_err;
    logic              halted;

    modport master (
        output imem_req, imem_addr, instr_valid, win_bytes, icode, ifun, need_regids,
               need_valC, instr_len, instr_pc, instr_err, halted,
        input  imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, win_bytes, icode, ifun, need_regids,
               need_valC, instr_len, instr_pc, instr_err, halted,
        output imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_byte_queue_predecode.sv
// predecode: splits the head byte into icode/ifun and derives operand needs and instruction length.
module predecode
    import fetch_pkg::*;
(
    input  logic [7:0] b0,
    output logic [3:0] icode,
    output logic [3:0] ifun,
    output logic       need_regids,
    output logic       need_valC,
    output logic [3:0] instr_len,
    output logic       instr_err
);
    assign icode       = b0[7:4];
    assign ifun        = b0[3:0];
    assign need_regids = f_need_regids(icode);
    assign need_valC   = f_need_valc(icode);
    // error icodes need nothing, so their length already comes out as 1
    assign instr_len   = f_instr_len(need_regids, need_valC);
    assign instr_err   = icode > IPOPQ;
endmodule

// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: 8-byte imem fetch into a circular byte queue feeding a 10-byte instruction window.
// Optional FETCH_STATS_EN adds saturating accepted-instruction and starve-cycle counters.
module fetch_byte_queue
    import fetch_pkg::*;
#(
    parameter int                QDEPTH   = QDEPTH_DEF,
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
    input logic clk,
    input logic reset,
    fetch_byte_queue_if.master bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_instr,
    output logic [31:0] stat_starve
`endif
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] ISSUE_MAX = CW'(QDEPTH - 8);

    logic [7:0]        q [QDEPTH];
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] fetch_pc, instr_pc;
    logic              pending, drop, halted;
    logic [79:0]       win;
    logic [3:0]        icode, ifun, len;
    logic              need_regids, need_valc, err;
    logic              valid, issue, accept, fill;

    always_comb begin
        win = '0;
        for (int k = 0; k < 10; k++)
            win[8*k +: 8] = (CW'(k) < count) ? q[head + PW'(k)] : 8'h00;
    end

    predecode u_predecode (
        .b0(win[7:0]), .icode(icode), .ifun(ifun), .need_regids(need_regids),
        .need_valC(need_valc), .instr_len(len), .instr_err(err)
    );

    assign valid  = (count != '0) && (err || count >= CW'(len));
    assign accept = valid && bus.instr_ready;
    assign issue  = !reset && !pending && (count <= ISSUE_MAX) && !halted && !bus.redirect;
    // pending is the outstanding tag: responses arriving without it (e.g. after reset) are ignored
    assign fill   = bus.imem_rvalid && pending && !drop;

    always_ff @(posedge clk) begin
        if (fill && !bus.redirect && !reset)
            for (int i = 0; i < 8; i++)
                q[tail + PW'(i)] <= bus.imem_rdata[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= RESET_PC;
            instr_pc <= RESET_PC;
            pending  <= 1'b0;
            drop     <= 1'b0;
            halted   <= 1'b0;
        end else if (bus.redirect) begin
            head     <= tail;
            count    <= '0;
            fetch_pc <= bus.redirect_pc;
            instr_pc <= bus.redirect_pc;
            halted   <= 1'b0;
            pending  <= pending && !bus.imem_rvalid;
            drop     <= pending && !bus.imem_rvalid;
        end else begin
            if (issue) begin
                pending  <= 1'b1;
                fetch_pc <= fetch_pc + ADDR_W'(8);
            end else if (bus.imem_rvalid && pending) begin
                pending <= 1'b0;
                drop    <= 1'b0;
            end
            if (fill)
                tail <= tail + PW'(8);
            if (accept) begin
                head     <= head + PW'(len);
                instr_pc <= instr_pc + ADDR_W'(len);
                halted   <= halted || (icode == IHALT);
            end
            count <= count - (accept ? CW'(len) : CW'(0)) + (fill ? CW'(8) : CW'(0));
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_instr  <= '0;
            stat_starve <= '0;
        end else begin
            if (accept && stat_instr != '1)
                stat_instr <= stat_instr + 32'd1;
            if (bus.instr_ready && !valid && stat_starve != '1)
                stat_starve <= stat_starve + 32'd1;
        end
    end
`endif

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = valid;
    assign bus.win_bytes   = win;
    assign bus.icode       = icode;
    assign bus.ifun        = ifun;
    assign bus.need_regids = need_regids;
    assign bus.need_valC   = need_valc;
    assign bus.instr_len   = len;
    assign bus.instr_pc    = instr_pc;
    assign bus.instr_err   = err;
    assign bus.halted      = halted;
endmodule

// File: tb/tb_fetch_byte_queue.sv
// tb_fetch_byte_queue: memory model with variable latency, accept scoreboard and predecode vector table.
module tb_fetch_byte_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_byte_queue_if #(.ADDR_W(64)) bus ();
`ifdef FETCH_STATS_EN
    logic [31:0] stat_instr, stat_starve;
`endif

    fetch_byte_queue #(.QDEPTH(16), .ADDR_W(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .bus(bus)
`ifdef FETCH_STATS_EN
        , .stat_instr(stat_instr), .stat_starve(stat_starve)
`endif
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [3:0]  len;
    } exp_t;

    typedef struct {
        logic [7:0] b0;
        logic       nr;
        logic       nv;
        logic [3:0] len;
        logic       err;
    } vec_t;

    exp_t        sb [$];
    vec_t        tbl [14];
    logic [7:0]  mem [4096];
    int          checks = 0, failures = 0;
    int          req_cnt = 0, m_instr = 0, m_starve = 0;
    int          lat = 1, cnt = 0;
    bit          busy = 0;
    logic [63:0] raddr;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // memory answers on the falling edge, `lat` cycles after it sees a request
    always @(negedge clk) begin
        bus.imem_rvalid = 1'b0;
        if (busy) begin
            if (cnt <= 1) begin
                bus.imem_rvalid = 1'b1;
                for (int i = 0; i < 8; i++)
                    bus.imem_rdata[8*i +: 8] = mem[12'(raddr + 64'(i))];
                busy = 0;
            end else
                cnt--;
        end
        if (bus.imem_req) begin
            busy  = 1;
            cnt   = lat;
            raddr = bus.imem_addr;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            m_instr  = 0;
            m_starve = 0;
        end else begin
            if (bus.instr_ready && !bus.instr_valid) m_starve++;
            if (bus.instr_ready && bus.instr_valid) m_instr++;
        end
        if (bus.imem_req) req_cnt++;
        if (bus.instr_valid && bus.instr_ready && sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_pc", bus.instr_pc, e.pc);
            chk("sb_icode", bus.icode, e.icode);
            chk("sb_len", bus.instr_len, e.len);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [63:0] pc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        step();
        bus.redirect = 1'b0;
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.instr_valid && n < 60) begin
            step();
            n++;
        end
        chk(name, bus.instr_valid, 1'b1);
    endtask

    initial begin
        int base;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h10;
        mem[0] = 8'h30;
        mem[1] = 8'hf4;
        for (int i = 2; i < 10; i++) mem[i] = 8'h00;
        mem[12'h800] = 8'h20; mem[12'h801] = 8'h12;
        mem[12'h900] = 8'h60; mem[12'h901] = 8'h12; mem[12'h902] = 8'h00;
        mem[12'hA07] = 8'hF0;
        tbl[0]  = '{8'h00, 0, 0, 4'd1, 0};
        tbl[1]  = '{8'h10, 0, 0, 4'd1, 0};
        tbl[2]  = '{8'h20, 1, 0, 4'd2, 0};
        tbl[3]  = '{8'h30, 1, 1, 4'd10, 0};
        tbl[4]  = '{8'h40, 1, 1, 4'd10, 0};
        tbl[5]  = '{8'h50, 1, 1, 4'd10, 0};
        tbl[6]  = '{8'h61, 1, 0, 4'd2, 0};
        tbl[7]  = '{8'h73, 0, 1, 4'd9, 0};
        tbl[8]  = '{8'h80, 0, 1, 4'd9, 0};
        tbl[9]  = '{8'h90, 0, 0, 4'd1, 0};
        tbl[10] = '{8'hA0, 1, 0, 4'd2, 0};
        tbl[11] = '{8'hB0, 1, 0, 4'd2, 0};
        tbl[12] = '{8'hC0, 0, 0, 4'd1, 1};
        tbl[13] = '{8'hF0, 0, 0, 4'd1, 1};
        for (int i = 0; i < 14; i++) begin
            mem[12'hB00 + 12'(16 * i)] = tbl[i].b0;
            for (int j = 1; j < 10; j++) mem[12'hB00 + 12'(16 * i + j)] = 8'h00;
        end

        step(2);
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_valid", bus.instr_valid, 1'b0);
        chk("rst_win", bus.win_bytes, 80'h0);
        chk("rst_halted", bus.halted, 1'b0);
        chk("rst_pc", bus.instr_pc, 64'h0);

        // irmovq from reset, 1-cycle memory, ready held high
        bus.instr_ready = 1'b1;
        reset = 1'b0;
        #1;
        chk("t1_req0", bus.imem_req, 1'b1);
        chk("t1_addr0", bus.imem_addr, 64'h0);
        step();
        chk("t1_req_busy", bus.imem_req, 1'b0);
        step();
        chk("t1_req1", bus.imem_req, 1'b1);
        chk("t1_addr1", bus.imem_addr, 64'h8);
        chk("t1_valid8", bus.instr_valid, 1'b0);
        step();
        chk("t1_valid_pre", bus.instr_valid, 1'b0);
        step();
        chk("t1_valid", bus.instr_valid, 1'b1);
        chk("t1_icode", bus.icode, 4'h3);
        chk("t1_nr", bus.need_regids, 1'b1);
        chk("t1_nv", bus.need_valC, 1'b1);
        chk("t1_len", bus.instr_len, 4'd10);
        chk("t1_pc", bus.instr_pc, 64'h0);
        chk("t1_win", bus.win_bytes, 80'hf430);
        step();
        chk("t1_pc2", bus.instr_pc, 64'h0A);
        chk("t1_icode2", bus.icode, 4'h1);

        // nop stream with ready low: fetch stops at a full queue, then drains one per cycle
        bus.instr_ready = 1'b0;
        redir(64'h400);
        base = req_cnt;
        step(20);
        chk("t2_reqs", req_cnt - base, 2);
        chk("t2_req_full", bus.imem_req, 1'b0);
        chk("t2_valid", bus.instr_valid, 1'b1);
        chk("t2_win", bus.win_bytes, 80'h10101010101010101010);
        for (int i = 0; i < 16; i++) sb.push_back(exp_t'{64'h400 + 64'(i), 4'h1, 4'd1});
        base = m_instr;
        bus.instr_ready = 1'b1;
        step(16);
        bus.instr_ready = 1'b0;
        chk("t2_accepts", m_instr - base, 16);
        chk("t2_sb_empty", sb.size(), 0);

        // redirect while a slow request is outstanding: its data must be dropped
        step(5);
        lat = 3;
        redir(64'hC00);
        chk("t3_req", bus.imem_req, 1'b1);
        chk("t3_addr", bus.imem_addr, 64'hC00);
        step();
        chk("t3_pending", bus.imem_req, 1'b0);
        redir(64'h800);
        wait_valid("t3_wait");
        chk("t3_pc", bus.instr_pc, 64'h800);
        chk("t3_icode", bus.icode, 4'h2);
        chk("t3_win", bus.win_bytes[15:0], 16'h1220);

        // OPq then halt; halt freezes fetch until a redirect
        lat = 1;
        redir(64'h900);
        wait_valid("t4_wait");
        chk("t4_icode", bus.icode, 4'h6);
        chk("t4_len", bus.instr_len, 4'd2);
        chk("t4_nr", bus.need_regids, 1'b1);
        chk("t4_nv", bus.need_valC, 1'b0);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("t4_halt_icode", bus.icode, 4'h0);
        chk("t4_halt_len", bus.instr_len, 4'd1);
        chk("t4_halt_pc", bus.instr_pc, 64'h902);
        chk("t4_not_halted", bus.halted, 1'b0);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("t4_halted", bus.halted, 1'b1);
        chk("t4_pc_after", bus.instr_pc, 64'h903);
        base = req_cnt;
        step(10);
        chk("t4_frozen", req_cnt - base, 0);
        redir(64'h400);
        chk("t4_unhalt", bus.halted, 1'b0);
        chk("t4_req_resume", bus.imem_req, 1'b1);

        // error byte at head with only one byte queued
        lat = 20;
        redir(64'hA00);
        wait_valid("t5_wait");
        bus.instr_ready = 1'b1;
        step(7);
        bus.instr_ready = 1'b0;
        #1;
        chk("t5_valid", bus.instr_valid, 1'b1);
        chk("t5_err", bus.instr_err, 1'b1);
        chk("t5_len", bus.instr_len, 4'd1);
        chk("t5_icode", bus.icode, 4'hF);
        chk("t5_pc", bus.instr_pc, 64'hA07);
        chk("t5_win", bus.win_bytes, 80'hF0);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("t5_empty", bus.instr_valid, 1'b0);
        chk("t5_no_req", bus.imem_req, 1'b0);

        // predecode vector table
        lat = 1;
        for (int i = 0; i < 14; i++) begin
            redir(64'hB00 + 64'(16 * i));
            wait_valid("tv_wait");
            chk("tv_icode", bus.icode, tbl[i].b0[7:4]);
            chk("tv_ifun", bus.ifun, tbl[i].b0[3:0]);
            chk("tv_nr", bus.need_regids, tbl[i].nr);
            chk("tv_nv", bus.need_valC, tbl[i].nv);
            chk("tv_len", bus.instr_len, tbl[i].len);
            chk("tv_err", bus.instr_err, tbl[i].err);
            chk("tv_pc", bus.instr_pc, 64'hB00 + 64'(16 * i));
        end

        // reset while a request is outstanding: its late data must be ignored
        step(5);
        lat = 2;
        redir(64'h400);
        chk("t6_req", bus.imem_req, 1'b1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("t6_pc_rst", bus.instr_pc, 64'h0);
        wait_valid("t6_wait");
        chk("t6_icode", bus.icode, 4'h3);
        chk("t6_byte0", bus.win_bytes[7:0], 8'h30);

`ifdef FETCH_STATS_EN
        step(5);
        bus.instr_ready = 1'b1;
        step(3);
        bus.instr_ready = 1'b0;
        step(2);
        chk("stat_instr", stat_instr, 80'(m_instr));
        chk("stat_starve", stat_starve, 80'(m_starve));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end
endmodule
